// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of {pc, instr}
// with full-stall to fetch and a taken-branch flush of wrong-path entries.
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     stall,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd;
    logic [PW-1:0] wr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = in_valid & ~full & ~flush;
    assign pop   = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wr <= wr + PW'(1);
            end
            if (pop) begin
                rd <= rd + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is never cleared; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr] <= {in_pc, in_instr};
        end
    end

    assign out_valid = ~empty;
    assign stall     = full;
    assign out_pc    = empty ? 32'h0 : mem[rd][63:32];
    assign out_instr = empty ? NOP : mem[rd][31:0];

endmodule
